// File: rtl/apb_i2c_master_v2_if.sv
// APB bus bundle for apb_i2c_master_v2.
// master drives sel/enable/write/addr/wdata; slave returns rdata/ready/slverr.
interface apb_i2c_master_v2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              apb_sel;
  logic              apb_enable;
  logic              apb_write;
  logic [ADDR_W-1:0] apb_addr;
  logic [DATA_W-1:0] apb_wdata;
  logic [DATA_W-1:0] apb_rdata;
  logic              apb_ready;
  logic              apb_slverr;

  modport master (
    output apb_sel, apb_enable, apb_write,
    output apb_addr, apb_wdata,
    input  apb_rdata, apb_ready, apb_slverr
  );

  modport slave (
    input  apb_sel, apb_enable, apb_write,
    input  apb_addr, apb_wdata,
    output apb_rdata, apb_ready, apb_slverr
  );
endinterface

// File: rtl/apb_i2c_master_v2.sv
// APB-programmed I2C write master with a TX byte FIFO.
// Ports: clk, rst_n, apb (slave modport), scl, sda_o/sda_oe/sda_i.
module apb_i2c_master_v2 #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RST    = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  apb_i2c_master_v2_if.slave apb,
  output logic               scl,
  output logic               sda_o,
  output logic               sda_oe,
  input  logic               sda_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK,
    S_DATA, S_DATA_ACK, S_STOP
  } st_t;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [4:0]        w_off;
  logic              w_acc, w_wr, w_rd;
  logic              w_hit_ctrl, w_hit_stat;
  logic              w_hit_saddr, w_hit_tx;
  logic              w_hit_div, w_map;
  logic              w_unused;

  logic              r_en;
  logic [6:0]        r_saddr;
  logic [15:0]       r_div;
  logic              r_nack;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [LW-1:0]     r_lvl;
  logic              w_full, w_empty;
  logic              w_push_req, w_push;
  logic              w_pop, w_flush;
  logic              w_set_nack;
  logic [7:0]        w_head;

  st_t               r_st, n_st;
  logic [1:0]        r_q, n_q;
  logic [2:0]        r_bit, n_bit;
  logic [7:0]        r_sh, n_sh;
  logic              r_ack, n_ack;
  logic              r_scl, n_scl;
  logic              r_sdo, n_sdo;
  logic              r_soe, n_soe;
  logic [15:0]       r_cnt, r_div_q;
  logic              w_tick, w_busy;

  logic              w_start_req, w_start_ok;
  logic [DATA_W-1:0] w_status, w_rdata;

  assign w_addr   = apb.apb_addr;
  assign w_wdata  = apb.apb_wdata;
  assign w_off    = w_addr[4:0];
  assign w_unused = ^{w_addr, w_wdata};

  assign w_acc = apb.apb_sel & apb.apb_enable;
  assign w_wr  = w_acc & apb.apb_write;
  assign w_rd  = w_acc & ~apb.apb_write;

  assign w_hit_ctrl  = (w_off == 5'h00);
  assign w_hit_stat  = (w_off == 5'h04);
  assign w_hit_saddr = (w_off == 5'h08);
  assign w_hit_tx    = (w_off == 5'h0C);
  assign w_hit_div   = (w_off == 5'h10);
  assign w_map = w_hit_ctrl | w_hit_stat
               | w_hit_saddr | w_hit_tx
               | w_hit_div;

  assign w_busy  = (r_st != S_IDLE);
  assign w_full  = (r_lvl == LW'(FIFO_DEPTH));
  assign w_empty = (r_lvl == '0);
  assign w_head  = r_mem[r_rp];

  // A push into a full FIFO is still taken when
  // the FSM frees a slot on the same edge.
  assign w_push_req = w_wr & w_hit_tx;
  assign w_push     = w_push_req
                    & (~w_full | w_pop);

  // START needs EN set in the same write.
  assign w_start_req = w_wr & w_hit_ctrl
                     & w_wdata[0];
  assign w_start_ok  = w_start_req & w_wdata[1]
                     & ~w_busy;

  assign w_status = DATA_W'({r_lvl, 3'b000,
                    r_nack, w_empty, w_full, w_busy});

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      unique case (1'b1)
        w_hit_ctrl:  w_rdata = DATA_W'({r_en, 1'b0});
        w_hit_stat:  w_rdata = w_status;
        w_hit_saddr: w_rdata = DATA_W'(r_saddr);
        w_hit_div:   w_rdata = DATA_W'(r_div);
        default:     w_rdata = '0;
      endcase
    end
  end

  assign apb.apb_rdata  = w_rdata;
  assign apb.apb_ready  = w_acc;
  assign apb.apb_slverr = w_acc & (~w_map
                        | (w_push_req & w_full & ~w_pop)
                        | (w_start_req & ~w_start_ok));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_saddr <= '0;
      r_div   <= 16'(DIV_RST);
      r_nack  <= 1'b0;
    end else begin
      if (w_wr & w_hit_ctrl)  r_en    <= w_wdata[1];
      if (w_wr & w_hit_saddr) r_saddr <= w_wdata[6:0];
      if (w_wr & w_hit_div)   r_div   <= w_wdata[15:0];
      if (w_set_nack)
        r_nack <= 1'b1;
      else if (w_wr & w_hit_stat & w_wdata[3])
        r_nack <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_flush) begin
        // A byte pushed on the flush edge survives.
        r_rp  <= r_wp;
        r_lvl <= LW'(w_push);
      end else begin
        if (w_pop) r_rp <= r_rp + 1'b1;
        r_lvl <= r_lvl + LW'(w_push) - LW'(w_pop);
      end
    end
  end

  // Each bit spans four quarters: q0/q1 SCL low,
  // q2/q3 SCL high. SDA moves on q0->q1 so it never
  // changes on an SCL edge; ACK sampled at q2->q3.
  assign w_tick = w_busy & (r_cnt == r_div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= S_IDLE;
      r_q     <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_ack   <= 1'b0;
      r_scl   <= 1'b1;
      r_sdo   <= 1'b1;
      r_soe   <= 1'b0;
      r_cnt   <= '0;
      r_div_q <= 16'(DIV_RST);
    end else begin
      r_st  <= n_st;
      r_q   <= n_q;
      r_bit <= n_bit;
      r_sh  <= n_sh;
      r_ack <= n_ack;
      r_scl <= n_scl;
      r_sdo <= n_sdo;
      r_soe <= n_soe;
      if (w_start_ok) r_div_q <= r_div;
      if (!w_busy || w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 16'd1;
    end
  end

  always_comb begin
    n_st       = r_st;
    n_q        = r_q;
    n_bit      = r_bit;
    n_sh       = r_sh;
    n_ack      = r_ack;
    n_scl      = r_scl;
    n_sdo      = r_sdo;
    n_soe      = r_soe;
    w_pop      = 1'b0;
    w_flush    = 1'b0;
    w_set_nack = 1'b0;
    if (r_st == S_IDLE) begin
      if (w_start_ok) begin
        n_st  = S_START;
        n_q   = 2'd0;
        n_bit = 3'd0;
        n_sh  = {r_saddr, 1'b0};
        n_scl = 1'b1;
        n_sdo = 1'b1;
        n_soe = 1'b1;
      end
    end else if (w_tick) begin
      n_q = r_q + 2'd1;
      case (r_st)
        S_START: begin
          if (r_q == 2'd1) n_sdo = 1'b0;
          if (r_q == 2'd2) n_scl = 1'b0;
          if (r_q == 2'd3) n_st  = S_ADDR;
        end
        S_ADDR, S_DATA: begin
          if (r_q == 2'd0) begin
            n_sdo = r_sh[7];
            n_soe = 1'b1;
          end
          if (r_q == 2'd1) n_scl = 1'b1;
          if (r_q == 2'd3) begin
            n_scl = 1'b0;
            n_sh  = {r_sh[6:0], 1'b0};
            n_bit = r_bit + 3'd1;
            if (r_bit == 3'd7)
              n_st = (r_st == S_ADDR) ? S_ADDR_ACK
                                      : S_DATA_ACK;
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (r_q == 2'd0) n_soe = 1'b0;
          if (r_q == 2'd1) n_scl = 1'b1;
          if (r_q == 2'd2) n_ack = sda_i;
          if (r_q == 2'd3) begin
            n_scl = 1'b0;
            if (r_ack) begin
              w_set_nack = 1'b1;
              w_flush    = 1'b1;
              n_st       = S_STOP;
            end else if (r_en && !w_empty) begin
              w_pop = 1'b1;
              n_sh  = w_head;
              n_st  = S_DATA;
            end else begin
              n_st = S_STOP;
            end
          end
        end
        S_STOP: begin
          if (r_q == 2'd0) begin
            n_sdo = 1'b0;
            n_soe = 1'b1;
          end
          if (r_q == 2'd1) n_scl = 1'b1;
          if (r_q == 2'd2) begin
            n_sdo = 1'b1;
            n_soe = 1'b0;
          end
          if (r_q == 2'd3) n_st = S_IDLE;
        end
        default: n_st = S_IDLE;
      endcase
    end
  end

  assign scl    = r_scl;
  assign sda_o  = r_sdo;
  assign sda_oe = r_soe;
endmodule

// File: tb/tb_apb_i2c_master_v2.sv
// Directed bench for apb_i2c_master_v2 with an I2C slave model.
// Checks registers, bus bits, ACK/NACK, FIFO limits and reset.
module tb_apb_i2c_master_v2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl, sda_o, sda_oe, sda_i;
  logic pull = 1'b0;
  logic nack_addr = 1'b0;
  logic w_line;

  apb_i2c_master_v2_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_i2c_master_v2 #(
    .ADDR_W(32), .DATA_W(32),
    .FIFO_DEPTH(8), .DIV_RST(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .apb(bus.slave),
    .scl(scl), .sda_o(sda_o), .sda_oe(sda_oe),
    .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  assign w_line = ~(sda_oe & ~sda_o) & ~pull;
  assign sda_i  = w_line;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_start = 0;
  int n_stop  = 0;
  logic q_bits[$];
  int   rise_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge scl) begin
    q_bits.push_back(w_line);
    rise_cyc.push_back(cyc);
  end

  // Slave pulls SDA low through the 9th clock of each byte.
  always @(negedge scl)
    pull = (q_bits.size() % 9 == 8)
         && !(nack_addr && q_bits.size() == 8);

  always @(negedge w_line) if (scl === 1'b1) n_start = n_start + 1;
  always @(posedge w_line) if (scl === 1'b1) n_stop = n_stop + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd,
                     output logic err, output logic rdy);
    @(posedge clk); #1;
    bus.apb_sel = 1'b1; bus.apb_enable = 1'b0;
    bus.apb_write = wr; bus.apb_addr = addr; bus.apb_wdata = wd;
    @(posedge clk); #1;
    bus.apb_enable = 1'b1;
    #1;
    rd = bus.apb_rdata; err = bus.apb_slverr; rdy = bus.apb_ready;
    @(posedge clk); #1;
    bus.apb_sel = 1'b0; bus.apb_enable = 1'b0; bus.apb_write = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    logic e, r;
    int k;
    d = 32'h1; k = 0;
    while (d[0] && k < 2000) begin
      apb(1'b0, 32'h04, 32'h0, d, e, r);
      k++;
    end
    chk(tag, {31'b0, d[0]}, 32'h0);
  endtask

  function automatic logic [7:0] byte_at(input int base);
    logic [7:0] b;
    b = 8'hxx;
    for (int i = 0; i < 8; i++)
      if (base + i < q_bits.size()) b[7-i] = q_bits[base+i];
    return b;
  endfunction

  function automatic logic bit_at(input int i);
    return (i < q_bits.size()) ? q_bits[i] : 1'bx;
  endfunction

  task automatic clear_mon();
    q_bits.delete(); rise_cyc.delete();
    n_start = 0; n_stop = 0;
  endtask

  logic [31:0] rd;
  logic err, rdy;
  int per;

  initial begin
    bus.apb_sel = 1'b0; bus.apb_enable = 1'b0; bus.apb_write = 1'b0;
    bus.apb_addr = '0; bus.apb_wdata = '0;
    #23;
    chk("rst_scl", {31'b0, scl}, 32'h1);
    chk("rst_sda_o", {31'b0, sda_o}, 32'h1);
    chk("rst_sda_oe", {31'b0, sda_oe}, 32'h0);
    chk("rst_ready", {31'b0, bus.apb_ready}, 32'h0);
    chk("rst_slverr", {31'b0, bus.apb_slverr}, 32'h0);
    chk("rst_rdata", bus.apb_rdata, 32'h0);
    rst_n = 1'b1;
    apb(1'b0, 32'h10, 0, rd, err, rdy); chk("rst_div", rd, 32'd24);
    apb(1'b0, 32'h04, 0, rd, err, rdy); chk("rst_status", rd, 32'h004);
    apb(1'b0, 32'h08, 0, rd, err, rdy); chk("rst_saddr", rd, 32'h0);
    apb(1'b0, 32'h00, 0, rd, err, rdy); chk("rst_ctrl", rd, 32'h0);

    apb(1'b0, 32'h14, 0, rd, err, rdy);
    chk("unmap_err", {31'b0, err}, 32'h1);
    chk("unmap_rdata", rd, 32'h0);
    chk("unmap_ready", {31'b0, rdy}, 32'h1);

    apb(1'b1, 32'h00, 32'h1, rd, err, rdy);
    chk("start_en0_err", {31'b0, err}, 32'h1);
    apb(1'b0, 32'h04, 0, rd, err, rdy); chk("start_en0_stat", rd, 32'h004);

    // Two-byte write with all ACKs
    apb(1'b1, 32'h10, 32'h1, rd, err, rdy);
    apb(1'b1, 32'h08, 32'h50, rd, err, rdy);
    apb(1'b1, 32'h0C, 32'hA5, rd, err, rdy);
    chk("push_err", {31'b0, err}, 32'h0);
    apb(1'b1, 32'h0C, 32'h3C, rd, err, rdy);
    apb(1'b1, 32'h00, 32'h2, rd, err, rdy);
    apb(1'b0, 32'h00, 0, rd, err, rdy); chk("ctrl_rd", rd, 32'h2);
    clear_mon();
    apb(1'b1, 32'h00, 32'h3, rd, err, rdy);
    chk("start_err", {31'b0, err}, 32'h0);
    apb(1'b0, 32'h04, 0, rd, err, rdy); chk("busy", {31'b0, rd[0]}, 32'h1);
    apb(1'b1, 32'h00, 32'h3, rd, err, rdy);
    chk("start_busy_err", {31'b0, err}, 32'h1);
    wait_idle("idle_a");
    chk("addr_byte", {24'b0, byte_at(0)}, 32'hA0);
    chk("addr_ack", {31'b0, bit_at(8)}, 32'h0);
    chk("data0", {24'b0, byte_at(9)}, 32'hA5);
    chk("data1", {24'b0, byte_at(18)}, 32'h3C);
    chk("nbits", q_bits.size(), 32'd28);
    chk("n_start", n_start, 32'd1);
    chk("n_stop", n_stop, 32'd1);
    per = (rise_cyc.size() > 2) ? rise_cyc[2] - rise_cyc[1] : -1;
    chk("scl_period", per, 32'd8);
    apb(1'b0, 32'h04, 0, rd, err, rdy); chk("stat_end", rd, 32'h004);

    // Address NACK with three bytes queued
    nack_addr = 1'b1;
    apb(1'b1, 32'h0C, 32'h11, rd, err, rdy);
    apb(1'b1, 32'h0C, 32'h22, rd, err, rdy);
    apb(1'b1, 32'h0C, 32'h33, rd, err, rdy);
    clear_mon();
    apb(1'b1, 32'h00, 32'h3, rd, err, rdy);
    wait_idle("idle_b");
    apb(1'b0, 32'h04, 0, rd, err, rdy); chk("nack_stat", rd, 32'h00C);
    chk("nack_nbits", q_bits.size(), 32'd10);
    chk("nack_stop", n_stop, 32'd1);
    apb(1'b1, 32'h04, 32'h8, rd, err, rdy);
    apb(1'b0, 32'h04, 0, rd, err, rdy); chk("nack_clr", rd, 32'h004);
    nack_addr = 1'b0;

    // Overfill while idle
    for (int i = 1; i <= 9; i++) begin
      apb(1'b1, 32'h0C, i, rd, err, rdy);
      chk($sformatf("fill_err%0d", i), {31'b0, err}, (i == 9) ? 32'h1 : 32'h0);
    end
    apb(1'b0, 32'h04, 0, rd, err, rdy); chk("full_stat", rd, 32'h402);

    // Push at FULL on the exact pop edge (80 clk after START)
    clear_mon();
    apb(1'b1, 32'h00, 32'h3, rd, err, rdy);
    repeat (77) @(posedge clk);
    apb(1'b1, 32'h0C, 32'h99, rd, err, rdy);
    chk("pushpop_err", {31'b0, err}, 32'h0);
    apb(1'b0, 32'h04, 0, rd, err, rdy); chk("pushpop_stat", rd, 32'h403);
    apb(1'b1, 32'h08, 32'h12, rd, err, rdy);
    wait_idle("idle_c");
    chk("pp_addr", {24'b0, byte_at(0)}, 32'hA0);
    for (int i = 1; i <= 8; i++)
      chk($sformatf("pp_data%0d", i), {24'b0, byte_at(9*i)}, i);
    chk("pp_last", {24'b0, byte_at(81)}, 32'h99);
    chk("pp_nbits", q_bits.size(), 32'd91);
    apb(1'b0, 32'h04, 0, rd, err, rdy); chk("pp_stat", rd, 32'h004);
    apb(1'b0, 32'h08, 0, rd, err, rdy); chk("saddr_late", rd, 32'h12);

    // Reset during a data byte
    apb(1'b1, 32'h08, 32'h50, rd, err, rdy);
    apb(1'b1, 32'h0C, 32'hAB, rd, err, rdy);
    apb(1'b1, 32'h0C, 32'hCD, rd, err, rdy);
    apb(1'b1, 32'h00, 32'h3, rd, err, rdy);
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_scl", {31'b0, scl}, 32'h1);
    chk("arst_sda_oe", {31'b0, sda_oe}, 32'h0);
    chk("arst_sda_o", {31'b0, sda_o}, 32'h1);
    #10 rst_n = 1'b1;
    apb(1'b0, 32'h04, 0, rd, err, rdy); chk("arst_stat", rd, 32'h004);
    apb(1'b0, 32'h10, 0, rd, err, rdy); chk("arst_div", rd, 32'd24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
